// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
//   Feeds the 3-to-8 select decoder. Destination-tagged words enter through a
//   valid/ready port and are held in a small FIFO. Each cycle the head word is
//   issued as a registered EN/S/DOUT triple when its channel is ready. A head
//   word that stays blocked for TIMEOUT consecutive cycles is discarded and
//   counted.
//
// Ports
//   CLK       clock, all state on rising edge
//   RST       asynchronous active-high reset
//   IN_VALID  input word valid
//   IN_READY  FIFO can accept a word (registered occupancy only)
//   IN_DEST   destination channel of the input word
//   IN_DATA   input payload
//   CH_RDY    per-channel ready, only the head's channel bit is looked at
//   EN        one-cycle issue strobe to decoder EN
//   S         channel select to decoder S (holds when EN=0)
//   DOUT      payload of the issued word (holds when EN=0)
//   DROP      one-cycle pulse when the head word is discarded on timeout
//   DROP_CNT  saturating count of dropped words
//   LEVEL     current FIFO occupancy
module demux_sel_sequencer #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [2:0]               IN_DEST,
  input  logic [DW-1:0]            IN_DATA,
  input  logic [7:0]               CH_RDY,
  output logic                     EN,
  output logic [2:0]               S,
  output logic [DW-1:0]            DOUT,
  output logic                     DROP,
  output logic [7:0]               DROP_CNT,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  // Wait counter only ever needs to reach TIMEOUT-1; with TIMEOUT=0 it just wraps.
  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef struct packed {
    logic [2:0]    dest;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level, level_nxt;
  logic [WCW-1:0]  wait_cnt, wcnt_nxt;
  state_t          state, state_nxt;

  entry_t          head;
  logic            push, pop, issue, drop;
  logic            head_rdy, timeout_hit;

  // Ready looks only at registered occupancy: a full FIFO never accepts,
  // even on a cycle that pops.
  assign IN_READY    = (level < LW'(DEPTH)) && !RST;
  assign push        = IN_VALID && IN_READY;
  assign head        = mem[rd_ptr];
  assign head_rdy    = CH_RDY[head.dest];
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WLIM);
  assign pop         = issue || drop;
  assign level_nxt   = level + LW'(push) - LW'(pop);
  assign LEVEL       = level;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: WAIT whenever a word is left after this edge's pop and push
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (push) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = (level_nxt != '0) ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-edge decision: issue, drop or keep waiting
  always_comb begin
    issue    = 1'b0;
    drop     = 1'b0;
    wcnt_nxt = '0;
    case (state)
      S_WAIT: begin
        if (head_rdy) begin
          issue = 1'b1;
        end else if (timeout_hit) begin
          drop = 1'b1;
        end else begin
          wcnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage has no reset; occupancy and pointers define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{dest: IN_DEST, data: IN_DATA};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wait_cnt <= '0;
      EN       <= 1'b0;
      S        <= '0;
      DOUT     <= '0;
      DROP     <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      // Power-of-2 depth: pointers wrap naturally
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      level    <= level_nxt;
      wait_cnt <= wcnt_nxt;
      EN       <= issue;
      DROP     <= drop;
      if (issue) begin
        S    <= head.dest;
        DOUT <= head.data;
      end
      if (drop && (DROP_CNT != 8'hFF)) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: a queue-based model of the sequencer is
// checked against the DUT every negedge, plus directed scenarios with
// hand-computed literal expectations.
module tb_demux_sel_sequencer;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [2:0] IN_DEST = '0;
  logic [7:0] IN_DATA = '0;
  logic [7:0] CH_RDY = '0;
  logic       EN;
  logic [2:0] S;
  logic [7:0] DOUT;
  logic       DROP;
  logic [7:0] DROP_CNT;
  logic [2:0] LEVEL;

  int tests = 0;
  int fails = 0;

  demux_sel_sequencer #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DEST(IN_DEST), .IN_DATA(IN_DATA), .CH_RDY(CH_RDY), .EN(EN), .S(S),
    .DOUT(DOUT), .DROP(DROP), .DROP_CNT(DROP_CNT), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: queue of {dest,data}; head is judged before this edge's push.
  logic [10:0] mq[$];
  int          m_wc = 0;
  int          m_cnt = 0;
  logic        m_en = 1'b0, m_drop = 1'b0;
  logic [2:0]  m_s = '0;
  logic [7:0]  m_dout = '0;

  always @(posedge CLK or posedge RST) begin : model
    logic [10:0] h;
    bit          acc;
    if (RST) begin
      mq.delete();
      m_wc = 0; m_cnt = 0; m_en = 1'b0; m_drop = 1'b0; m_s = '0; m_dout = '0;
    end else begin
      acc    = IN_VALID && (mq.size() < DEPTH);
      m_en   = 1'b0;
      m_drop = 1'b0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (CH_RDY[h[10:8]]) begin
          m_en = 1'b1; m_s = h[10:8]; m_dout = h[7:0];
          void'(mq.pop_front());
          m_wc = 0;
        end else if (TIMEOUT != 0 && m_wc == TIMEOUT - 1) begin
          m_drop = 1'b1;
          void'(mq.pop_front());
          if (m_cnt < 255) m_cnt++;
          m_wc = 0;
        end else begin
          m_wc++;
        end
      end
      if (acc) mq.push_back({IN_DEST, IN_DATA});
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("in_ready", IN_READY, (mq.size() < DEPTH) ? 1 : 0);
      chk("level", LEVEL, mq.size());
      chk("en", EN, m_en);
      chk("drop", DROP, m_drop);
      chk("drop_cnt", DROP_CNT, m_cnt);
      chk("s", S, m_s);
      chk("dout", DOUT, m_dout);
      chk("en_drop_excl", EN & DROP, 0);
    end
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int drops;
    #1 RST = 1'b1;
    #1;
    chk("rst_en", EN, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_drop_cnt", DROP_CNT, 0);
    chk("rst_in_ready", IN_READY, 0);
    @(negedge CLK);
    @(negedge CLK);
    #1 RST = 1'b0;

    // Single word
    @(negedge CLK);
    chk("t1_in_ready", IN_READY, 1);
    CH_RDY = 8'hFF; IN_VALID = 1'b1; IN_DEST = 3'd5; IN_DATA = 8'hA3;
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("t1_en_early", EN, 0);
    chk("t1_level1", LEVEL, 1);
    @(negedge CLK);
    chk("t1_en", EN, 1);
    chk("t1_s", S, 5);
    chk("t1_dout", DOUT, 8'hA3);
    chk("t1_level0", LEVEL, 0);
    @(negedge CLK);
    chk("t1_en_once", EN, 0);
    chk("t1_drop_cnt", DROP_CNT, 0);

    // Full and backpressure
    CH_RDY = 8'h00;
    for (int i = 0; i < 6; i++) begin
      IN_VALID = 1'b1; IN_DEST = 3'(i); IN_DATA = 8'(8'h10 + i);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    chk("t2_level_full", LEVEL, 4);
    chk("t2_in_ready_full", IN_READY, 0);
    CH_RDY = 8'hFF;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      chk("t2_en", EN, 1);
      chk("t2_dout", DOUT, 8'h10 + j);
      chk("t2_s", S, j);
      if (j == 0) chk("t2_ready_after_pop", IN_READY, 1);
    end
    @(negedge CLK);
    chk("t2_en_done", EN, 0);

    // Streaming with pointer wrap
    for (int c = 0; c < 22; c++) begin
      if (c >= 2) begin
        chk("t3_en", EN, 1);
        chk("t3_s", S, (c - 2) % 8);
        chk("t3_dout", DOUT, c - 2);
      end
      chk("t3_level_le1", (LEVEL <= 1) ? 1 : 0, 1);
      IN_VALID = (c < 20);
      IN_DEST  = 3'(c % 8);
      IN_DATA  = 8'(c);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;

    // Head-of-line blocking and timeout
    CH_RDY = 8'b0000_1000;
    for (int c = 0; c < 19; c++) begin
      if (c >= 1 && c <= 16) begin
        chk("t4_blocked_en", EN, 0);
        chk("t4_blocked_drop", DROP, 0);
      end
      if (c == 17) begin
        chk("t4_drop", DROP, 1);
        chk("t4_drop_cnt", DROP_CNT, 1);
        chk("t4_drop_en", EN, 0);
      end
      if (c == 18) begin
        chk("t4_en", EN, 1);
        chk("t4_s", S, 3);
        chk("t4_dout", DOUT, 8'h41);
      end
      IN_VALID = (c < 2);
      IN_DEST  = (c == 0) ? 3'd2 : 3'd3;
      IN_DATA  = 8'(8'h40 + c);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;

    // Drop counter saturation
    CH_RDY = 8'h00; IN_VALID = 1'b1; IN_DEST = 3'd1; IN_DATA = 8'h77;
    drops = 0;
    repeat (260 * 16 + 32) begin
      @(negedge CLK);
      if (DROP) drops++;
    end
    chk("t5_drop_pulses", (drops >= 260) ? 1 : 0, 1);
    chk("t5_drop_cnt_sat", DROP_CNT, 255);
    IN_VALID = 1'b0; CH_RDY = 8'hFF;
    repeat (6) @(negedge CLK);
    chk("t5_drained", LEVEL, 0);
    chk("t5_cnt_held", DROP_CNT, 255);

    // Reset mid-operation
    CH_RDY = 8'h00;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; IN_DEST = 3'(i); IN_DATA = 8'(8'h60 + i);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    chk("t6_level3", LEVEL, 3);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_en", EN, 0);
    chk("t6_rst_drop", DROP, 0);
    chk("t6_rst_level", LEVEL, 0);
    chk("t6_rst_drop_cnt", DROP_CNT, 0);
    chk("t6_rst_in_ready", IN_READY, 0);
    #1 RST = 1'b0;
    CH_RDY = 8'hFF;
    repeat (20) begin
      @(negedge CLK);
      chk("t6_no_issue", EN, 0);
      chk("t6_empty", LEVEL, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
